// File: rtl/filter_pkg.sv
// Shared types and defaults for the sample filter stage.
package filter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        MODE_MUTE   = 2'd0,
        MODE_BYPASS = 2'd1,
        MODE_FIR    = 2'd2,
        MODE_IIR    = 2'd3
    } mode_e;

endpackage

// File: rtl/moving_avg_core.sv
// N-tap moving average: circular delay line, running sum, write pointer
// and fill counter. avg_o is the average including the sample on x_i, valid
// in the same cycle as valid_i, so the caller can register it alongside.
module moving_avg_core
    import filter_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int FIR_TAPS_LOG2 = 3
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         clear_i,
    input  logic                         valid_i,
    input  logic signed [DATA_WIDTH-1:0] x_i,
    output logic signed [DATA_WIDTH-1:0] avg_o,
    output logic                         full_o
);

    localparam int DEPTH = 1 << FIR_TAPS_LOG2;
    localparam int SUM_W = DATA_WIDTH + FIR_TAPS_LOG2;
    localparam logic [FIR_TAPS_LOG2:0] DEPTH_CNT = (FIR_TAPS_LOG2+1)'(DEPTH);

    logic signed [DATA_WIDTH-1:0] line_q [DEPTH];
    logic signed [DATA_WIDTH-1:0] line_d [DEPTH];
    logic signed [SUM_W-1:0]      sum_q, sum_d, sum_base, sum_new;
    logic [FIR_TAPS_LOG2-1:0]     ptr_q, ptr_d, ptr_base;
    logic [FIR_TAPS_LOG2:0]       fill_q, fill_d, fill_base;
    logic signed [DATA_WIDTH-1:0] old_x;

    // Next-state: a clear wipes the window first, then a same-cycle sample
    // is applied on top of the empty window.
    always_comb begin
        line_d    = line_q;
        sum_base  = sum_q;
        ptr_base  = ptr_q;
        fill_base = fill_q;
        old_x     = line_q[ptr_q];
        if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                line_d[i] = '0;
            end
            sum_base  = '0;
            ptr_base  = '0;
            fill_base = '0;
            old_x     = '0;
        end
        sum_new = sum_base + SUM_W'(x_i) - SUM_W'(old_x);
        sum_d   = sum_base;
        ptr_d   = ptr_base;
        fill_d  = fill_base;
        if (valid_i) begin
            line_d[ptr_base] = x_i;
            sum_d            = sum_new;
            ptr_d            = ptr_base + FIR_TAPS_LOG2'(1);
            if (fill_base != DEPTH_CNT) begin
                fill_d = fill_base + (FIR_TAPS_LOG2+1)'(1);
            end
        end
        avg_o = DATA_WIDTH'(sum_new >>> FIR_TAPS_LOG2);
    end

    // Window state registers.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                line_q[i] <= '0;
            end
            sum_q  <= '0;
            ptr_q  <= '0;
            fill_q <= '0;
        end else begin
            line_q <= line_d;
            sum_q  <= sum_d;
            ptr_q  <= ptr_d;
            fill_q <= fill_d;
        end
    end

    assign full_o = (fill_q == DEPTH_CNT);

endmodule

// File: rtl/sample_filter.sv
// Sample processing stage: mute / bypass / moving-average / exponential
// smoothing, two-cycle fixed latency, one sample per cycle.
// Handshake: sample_valid_i is a one-cycle strobe with no back-pressure;
// each strobe produces exactly one sample_valid_o strobe two cycles later.
module sample_filter
    import filter_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int FIR_TAPS_LOG2 = 3,
    parameter int IIR_SHIFT     = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  mode_e                        mode_i,
    input  logic                         sample_valid_i,
    input  logic signed [DATA_WIDTH-1:0] sample_i,
    output logic                         sample_valid_o,
    output logic signed [DATA_WIDTH-1:0] sample_o,
    output logic                         window_full_o
);

    mode_e                        mode_q, mode_d;
    logic                         clear;
    logic signed [DATA_WIDTH-1:0] fir_avg;

    logic signed [DATA_WIDTH-1:0] y_q, y_d, y_base, y_new;
    logic signed [DATA_WIDTH:0]   diff;

    logic                         s1_valid_q, s1_valid_d;
    mode_e                        s1_mode_q, s1_mode_d;
    logic signed [DATA_WIDTH-1:0] s1_x_q, s1_x_d;
    logic signed [DATA_WIDTH-1:0] s1_fir_q, s1_fir_d;
    logic signed [DATA_WIDTH-1:0] s1_iir_q, s1_iir_d;

    logic                         sample_valid_o_q, sample_valid_o_d;
    logic signed [DATA_WIDTH-1:0] sample_o_q, sample_o_d;

    moving_avg_core #(
        .DATA_WIDTH   (DATA_WIDTH),
        .FIR_TAPS_LOG2(FIR_TAPS_LOG2)
    ) u_moving_avg (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .clear_i (clear),
        .valid_i (sample_valid_i),
        .x_i     (sample_i),
        .avg_o   (fir_avg),
        .full_o  (window_full_o)
    );

    // Mode tracking, IIR update and stage-1 capture of candidate results.
    always_comb begin
        clear  = (mode_i != mode_q);
        mode_d = mode_i;

        y_base = clear ? '0 : y_q;
        diff   = (DATA_WIDTH+1)'(sample_i) - (DATA_WIDTH+1)'(y_base);
        y_new  = y_base + DATA_WIDTH'(diff >>> IIR_SHIFT);
        y_d    = sample_valid_i ? y_new : y_base;

        s1_valid_d = sample_valid_i;
        s1_mode_d  = s1_mode_q;
        s1_x_d     = s1_x_q;
        s1_fir_d   = s1_fir_q;
        s1_iir_d   = s1_iir_q;
        if (sample_valid_i) begin
            s1_mode_d = mode_i;
            s1_x_d    = sample_i;
            s1_fir_d  = fir_avg;
            s1_iir_d  = y_new;
        end
    end

    // Stage 2: pick the result for the mode the sample was captured with.
    always_comb begin
        sample_valid_o_d = s1_valid_q;
        sample_o_d       = sample_o_q;
        if (s1_valid_q) begin
            unique case (s1_mode_q)
                MODE_MUTE:   sample_o_d = '0;
                MODE_BYPASS: sample_o_d = s1_x_q;
                MODE_FIR:    sample_o_d = s1_fir_q;
                MODE_IIR:    sample_o_d = s1_iir_q;
                default:     sample_o_d = '0;
            endcase
        end
    end

    // Pipeline, mode and IIR state registers.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            mode_q           <= MODE_MUTE;
            y_q              <= '0;
            s1_valid_q       <= 1'b0;
            s1_mode_q        <= MODE_MUTE;
            s1_x_q           <= '0;
            s1_fir_q         <= '0;
            s1_iir_q         <= '0;
            sample_valid_o_q <= 1'b0;
            sample_o_q       <= '0;
        end else begin
            mode_q           <= mode_d;
            y_q              <= y_d;
            s1_valid_q       <= s1_valid_d;
            s1_mode_q        <= s1_mode_d;
            s1_x_q           <= s1_x_d;
            s1_fir_q         <= s1_fir_d;
            s1_iir_q         <= s1_iir_d;
            sample_valid_o_q <= sample_valid_o_d;
            sample_o_q       <= sample_o_d;
        end
    end

    assign sample_valid_o = sample_valid_o_q;
    assign sample_o       = sample_o_q;

endmodule

// File: tb/tb_sample_filter.sv
// Directed bench for sample_filter with an expected-value queue and a
// monitor that checks every output strobe for value and latency.
module tb_sample_filter;
    import filter_pkg::*;

    localparam int DW = 16;

    logic                 clk_i = 1'b0;
    logic                 reset_ni = 1'b0;
    mode_e                mode_i = MODE_MUTE;
    logic                 sample_valid_i = 1'b0;
    logic signed [DW-1:0] sample_i = '0;
    logic                 sample_valid_o;
    logic signed [DW-1:0] sample_o;
    logic                 window_full_o;

    sample_filter #(
        .DATA_WIDTH   (DW),
        .FIR_TAPS_LOG2(3),
        .IIR_SHIFT    (4)
    ) dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .mode_i        (mode_i),
        .sample_valid_i(sample_valid_i),
        .sample_i      (sample_i),
        .sample_valid_o(sample_valid_o),
        .sample_o      (sample_o),
        .window_full_o (window_full_o)
    );

    // Clock and cycle counter
    always #10 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Scoreboard state
    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every output strobe must match the head of the queue
    always @(negedge clk_i) begin
        if (sample_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d, expected no strobe (t=%0t)",
                         sample_o, $time);
            end else begin
                logic [DW-1:0] e;
                int            c;
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("sample_o", int'(sample_o), int'($signed(e)));
                check("latency_cycle", cyc, c);
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input mode_e m, input int n);
        mode_i = m;
        repeat (n) tick();
    endtask

    task automatic send(input mode_e m, input int x, input int e);
        mode_i         = m;
        sample_valid_i = 1'b1;
        sample_i       = DW'(x);
        exp_q.push_back(DW'(e));
        exp_cyc_q.push_back(cyc + 2);
        tick();
        sample_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
        exp_cyc_q.delete();
        tick();
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    int iir_exp[7] = '{100, 193, 280, 362, 439, 511, 579};
    int byp_vals[4] = '{100, -200, 32767, -32768};

    // Directed test sequence
    initial begin
        // Reset held with valids driven
        reset_ni       = 1'b0;
        mode_i         = MODE_BYPASS;
        sample_valid_i = 1'b1;
        sample_i       = 16'sd1234;
        repeat (3) begin
            tick();
            check("rst_valid_o", int'(sample_valid_o), 0);
            check("rst_sample_o", int'(sample_o), 0);
            check("rst_window_full", int'(window_full_o), 0);
        end
        sample_valid_i = 1'b0;
        reset_ni       = 1'b1;
        idle(MODE_MUTE, 1);
        send(MODE_MUTE, 500, 0);
        drain();

        // Reset mid-flight drops the in-flight sample
        idle(MODE_BYPASS, 1);
        mode_i         = MODE_BYPASS;
        sample_valid_i = 1'b1;
        sample_i       = 16'sd77;
        tick();
        sample_valid_i = 1'b0;
        reset_ni       = 1'b0;
        tick();
        reset_ni = 1'b1;
        repeat (3) tick();
        check("midrst_sample_o", int'(sample_o), 0);

        // Bypass, back-to-back
        idle(MODE_BYPASS, 1);
        for (int i = 0; i < 4; i++) send(MODE_BYPASS, byp_vals[i], byp_vals[i]);
        drain();

        // FIR step
        idle(MODE_FIR, 1);
        for (int i = 1; i <= 7; i++) send(MODE_FIR, 800, 100 * i);
        check("fir_full_after7", int'(window_full_o), 0);
        send(MODE_FIR, 800, 800);
        check("fir_full_after8", int'(window_full_o), 1);
        send(MODE_FIR, 0, 700);
        drain();

        // FIR wrap and negatives
        idle(MODE_BYPASS, 1);
        idle(MODE_FIR, 1);
        for (int i = 1; i <= 8; i++) send(MODE_FIR, -8, -i);
        for (int i = 1; i <= 8; i++) send(MODE_FIR, 8, -8 + 2 * i);
        drain();

        // IIR step
        idle(MODE_IIR, 1);
        for (int i = 0; i < 7; i++) send(MODE_IIR, 1600, iir_exp[i]);
        drain();

        // Mute with the same stimulus
        idle(MODE_MUTE, 1);
        for (int i = 0; i < 4; i++) send(MODE_MUTE, 1600, 0);
        drain();

        // Mode switch clears state
        idle(MODE_FIR, 1);
        for (int i = 1; i <= 8; i++) send(MODE_FIR, 800, 100 * i);
        check("switch_full_before", int'(window_full_o), 1);
        send(MODE_IIR, 1600, 100);
        check("switch_full_after", int'(window_full_o), 0);
        drain();
        send(MODE_FIR, 800, 100);
        check("return_full", int'(window_full_o), 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_filter.md
Name: sample_filter

Overview:
- Parametrised sample-processing stage between the ADC reader and the DAC writer.
- Replaces the fixed mute/bypass mux with a real filter path: mute, bypass, N-tap moving-average FIR, and first-order IIR (exponential smoothing).
- Consumes one signed sample per valid pulse, typically once per TickGen tick.
- Emits the filtered sample with a valid pulse at fixed latency, ready to feed the DAC writer's data input.

Parameters:
- DATA_WIDTH, 16: sample width, signed two's complement.
- FIR_TAPS_LOG2, 3: log2 of FIR window length (default 8 taps); legal range 1..6.
- IIR_SHIFT, 4: smoothing factor; alpha = 2^-IIR_SHIFT; legal range 1..8.

Ports:
- clk_i  in  1  system clock (50 MHz).
- reset_ni  in  1  synchronous, active-low reset.
- mode_i  in  2  filter mode (filter_pkg::mode_e); sampled every cycle.
- sample_valid_i  in  1  one-cycle strobe, sample_i valid.
- sample_i  in  DATA_WIDTH  signed input sample.
- sample_valid_o  out  1  one-cycle strobe, sample_o updated.
- sample_o  out  DATA_WIDTH  signed filtered sample; holds between strobes.
- window_full_o  out  1  FIR window has received at least 2^FIR_TAPS_LOG2 samples since last clear.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset_ni=0 at clk edge) clears all of the following to 0: sample_valid_o, sample_o, window_full_o, delay line, running sum, write pointer, fill counter, IIR state, pipeline valid. The registered mode becomes MODE_MUTE.
- Reset mid-operation: any in-flight sample is dropped; no sample_valid_o pulse for it.
- Modes:
  - MODE_MUTE=0: output 0.
  - MODE_BYPASS=1: output x.
  - MODE_FIR=2: moving average.
  - MODE_IIR=3: exponential smoothing.
- Pipeline, 2 cycles of latency:
  - Stage 1 (edge after sample_valid_i): update filter state and register the candidate results.
  - Stage 2: select by registered mode into sample_o and pulse sample_valid_o.
  - sample_valid_o is high exactly 2 cycles after each sample_valid_i.
- Back-to-back valids on every cycle are accepted; throughput is 1 sample per cycle.
- FIR datapath:
  - Circular delay line of 2^FIR_TAPS_LOG2 entries.
  - Running sum width is DATA_WIDTH+FIR_TAPS_LOG2.
  - On valid: sum <= sum + x - line[ptr]; line[ptr] <= x; ptr <= ptr+1, wrapping modulo depth.
  - FIR result = (new sum) >>> FIR_TAPS_LOG2 (arithmetic shift, truncation toward -inf). No saturation is needed.
  - Before the window fills, the empty slots count as 0, so the output ramps up.
  - Fill counter saturates at the depth; window_full_o rises on the valid that completes the window.
- IIR datapath:
  - State y, DATA_WIDTH bits.
  - diff = x - y, computed at DATA_WIDTH+1 bits.
  - y <= y + (diff >>> IIR_SHIFT).
  - The result is a convex combination, so it stays in range; no saturation.
- Both FIR and IIR state update on every valid regardless of mode, so switching between them is seamless unless the clear rule below fires.
- Mode change: on any cycle where mode_i differs from the registered mode, the following happens:
  - The registered mode updates.
  - FIR line, sum, ptr, fill counter and IIR state clear to 0, and window_full_o drops.
  - A sample valid in that same cycle is processed with the cleared state and the new mode.
  - A sample already in stage 2 is output under the mode captured with it at stage 1.
- With no valid, all state holds and sample_o holds its last value.

Decomposition:
- filter_pkg holds:
  - typedef enum logic [1:0] mode_e {MODE_MUTE, MODE_BYPASS, MODE_FIR, MODE_IIR}.
  - The default width localparam.
- One sub-module, moving_avg_core. It contains the delay line, running sum, pointer and fill counter, and has ports clk_i, reset_ni, clear_i, valid_i, x_i, avg_o, full_o.
- The IIR update, mode register, clear detection and output mux stay in sample_filter.

Test Plan:
- Reset: hold reset_ni=0 for 3 cycles while driving valids → sample_valid_o=0, sample_o=0, window_full_o=0. First valid after release yields sample_valid_o exactly 2 cycles later.
- Bypass latency/throughput: mode=1, valids on 4 consecutive cycles with 100, -200, 32767, -32768 → the same 4 values on 4 consecutive sample_valid_o pulses, each 2 cycles late.
- FIR step (defaults): mode=2, eight samples of 800 → outputs 100, 200, …, 800. window_full_o rises with the 8th. A 9th sample of 0 → 700.
- FIR wrap and negatives: mode=2, eight samples of -8 then eight of 8 → outputs ramp -1..-8, then -6, -4, …, 8. Checks pointer wrap and arithmetic shift.
- IIR step (defaults): mode=3, repeated samples of 1600 → outputs 100, 193, 280, … monotonically approaching 1600, never exceeding it. Mute (mode=0) with the same stimulus → all outputs 0, valid pulses still present.
- Mode switch clear: mode=2, feed 8×800 (window full); switch to mode=3 in the same cycle as a valid of 1600 → window_full_o=0, that output is 100, and the FIR state is zero on return to mode 2.
